uart_tx_arbiter: RTL and testbench

Shares one `uart_tx` instance between two byte producers, e.g. the RX echo path and a status/message source. Each producer gets a one-entry holding buffer behind a valid/ready handshake. A round-robin arbiter picks the next byte, issues a one-cycle `tx_start` with stable `tx_data`, and tracks `tx_busy` until the frame is finished. The block sits between the producers and `uart_tx`, in place of ad-hoc `tx_start` sequencing logic in the top-level.

---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of a single uart_tx between two byte producers.
// Each port holds one byte; the FSM issues tx_start and follows tx_busy until the frame ends.
module uart_tx_arbiter #(
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic [1:0] grant,
   output logic       err_timeout
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               last_reg, last_next;
   logic               start_reg, start_next;
   logic [7:0]         data_reg, data_next;
   logic [1:0]         grant_reg, grant_next;
   logic               err_reg, err_next;

   logic [1:0]         req_valid;
   logic [7:0]         req_data [2];
   logic [1:0]         full;
   logic [7:0]         buf_q [2];
   logic [1:0]         release_port;
   logic               winner;

   assign req_valid   = {req1_valid, req0_valid};
   assign req_data[0] = req0_data;
   assign req_data[1] = req1_data;

   // A port's buffer is freed on the edge that leaves START for its grant.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic       full_reg;
      logic [7:0] buf_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            full_reg <= 1'b0;
            buf_reg  <= 8'h00;
         end else if (req_valid[gi] && !full_reg) begin
            full_reg <= 1'b1;
            buf_reg  <= req_data[gi];
         end else if (release_port[gi]) begin
            full_reg <= 1'b0;
         end
      end

      assign full[gi]         = full_reg;
      assign buf_q[gi]        = buf_reg;
      assign release_port[gi] = (state_reg == START) && grant_reg[gi];
   end

   // With both full the port that did not go last wins; otherwise the only full one.
   assign winner = (full == 2'b11) ? ~last_reg : full[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         last_reg  <= 1'b1;
         start_reg <= 1'b0;
         data_reg  <= 8'h00;
         grant_reg <= 2'b00;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         last_reg  <= last_next;
         start_reg <= start_next;
         data_reg  <= data_next;
         grant_reg <= grant_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      last_next  = last_reg;
      start_next = 1'b0;
      data_next  = data_reg;
      grant_next = grant_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if ((|full) && !tx_busy) begin
               state_next = START;
               start_next = 1'b1;
               grant_next = winner ? 2'b10 : 2'b01;
               data_next  = winner ? buf_q[1] : buf_q[0];
               last_next  = winner;
            end
         end
         START: begin
            state_next = WAIT_BUSY;
            cnt_next   = '0;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end else if (cnt_reg == CNT_W'(BUSY_TIMEOUT - 1)) begin
               err_next   = 1'b1;
               grant_next = 2'b00;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               grant_next = 2'b00;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign req0_ready  = !full[0];
   assign req1_ready  = !full[1];
   assign tx_start    = start_reg;
   assign tx_data     = data_reg;
   assign grant       = grant_reg;
   assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random producers, checked each cycle
// against a timeline model of the arbitration rules, with a small uart_tx busy emulator.
module tb_uart_tx_arbiter;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_ready, req1_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy = 1'b0;
   logic [1:0] grant;
   logic       err_timeout;

   uart_tx_arbiter #(.BUSY_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant(grant), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending byte per port, and the current frame as an age
   // counted in edges since its grant.
   bit       m_full [2];
   bit [7:0] m_buf [2];
   int       m_last;
   bit       m_active, m_busy_seen;
   int       m_owner, m_age;
   bit       m_start, m_err;
   bit [1:0] m_grant;
   bit [7:0] m_data;
   bit       m_acc [2];
   int       acc_total = 0;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_full[i] = 0; m_buf[i] = 8'h00; m_acc[i] = 0;
      end
      m_last = 1; m_active = 0; m_busy_seen = 0; m_owner = 0; m_age = 0;
      m_start = 0; m_err = 0; m_grant = 2'b00; m_data = 8'h00;
   endtask

   task automatic model_edge();
      int w;
      m_acc[0] = req0_valid && !m_full[0];
      m_acc[1] = req1_valid && !m_full[1];
      if (!m_active) begin
         if ((m_full[0] || m_full[1]) && !tx_busy) begin
            if (m_full[0] && m_full[1]) w = 1 - m_last;
            else w = m_full[0] ? 0 : 1;
            m_active = 1; m_owner = w; m_age = 0; m_busy_seen = 0;
            m_start = 1; m_grant = (w == 1) ? 2'b10 : 2'b01;
            m_data = m_buf[w]; m_last = w;
         end
      end else begin
         m_age++;
         if (m_age == 1) begin
            m_start = 0;
            m_full[m_owner] = 0;
         end else if (!m_busy_seen) begin
            if (tx_busy) m_busy_seen = 1;
            else if (m_age == 1 + T) begin
               m_err = 1; m_active = 0; m_grant = 2'b00;
            end
         end else if (!tx_busy) begin
            m_active = 0; m_grant = 2'b00;
         end
      end
      if (m_acc[0]) begin m_full[0] = 1; m_buf[0] = req0_data; acc_total++; end
      if (m_acc[1]) begin m_full[1] = 1; m_buf[1] = req1_data; acc_total++; end
   endtask

   // uart_tx emulator: busy rises emu_delay cycles after tx_start, stays up emu_left cycles.
   bit emu_armed = 0, emu_ignore = 0, emu_fixed = 0;
   int emu_delay, emu_left, fix_delay = 1, fix_len = 10;

   task automatic emu_update();
      if (tx_start === 1'b1 && !emu_armed) begin
         if (!(emu_ignore || (!emu_fixed && $urandom_range(0, 7) == 0))) begin
            emu_armed = 1;
            emu_delay = emu_fixed ? fix_delay : int'($urandom_range(0, 2));
            emu_left  = emu_fixed ? fix_len : int'($urandom_range(1, 6));
         end
      end
      if (emu_armed) begin
         if (emu_delay > 0) begin emu_delay--; tx_busy = 1'b0; end
         else if (emu_left > 0) begin emu_left--; tx_busy = 1'b1; end
         else begin tx_busy = 1'b0; emu_armed = 0; end
      end else begin
         tx_busy = 1'b0;
      end
   endtask

   logic [7:0] tx_log [$];

   task automatic compare_all();
      check_eq("tx_start", tx_start, m_start);
      check_eq("grant", grant, m_grant);
      check_eq("tx_data", tx_data, m_data);
      check_eq("req0_ready", req0_ready, !m_full[0]);
      check_eq("req1_ready", req1_ready, !m_full[1]);
      check_eq("err_timeout", err_timeout, m_err);
   endtask

   task automatic step();
      @(negedge clk);
      emu_update();
      if (!rst_n) model_reset();
      else model_edge();
      @(posedge clk);
      #1;
      compare_all();
      if (tx_start === 1'b1) begin
         tx_log.push_back(tx_data);
         $display("tx byte=%02h grant=%b t=%0t", tx_data, grant, $time);
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_data = 8'hC0;
      #1;
      model_reset();
      compare_all();
      check_eq("rst_ready", {req1_ready, req0_ready}, 2'b11);
      repeat (n) step();
      rst_n = 1'b1;
      req0_valid = 1'b0;
      $display("reset released t=%0t", $time);
   endtask

   task automatic offer(input bit use0, input bit use1, input logic [7:0] d0, input logic [7:0] d1);
      int n = 0;
      bit p0 = use0, p1 = use1;
      req0_valid = p0; req0_data = d0;
      req1_valid = p1; req1_data = d1;
      while ((p0 || p1) && n < 50) begin
         step();
         n++;
         if (m_acc[0]) begin p0 = 0; req0_valid = 1'b0; end
         if (m_acc[1]) begin p1 = 0; req1_valid = 1'b0; end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check_eq("offer_taken", {p1, p0}, 2'b00);
   endtask

   task automatic wait_start();
      int n = 0;
      int s = tx_log.size();
      while (tx_log.size() == s && n < 30) begin step(); n++; end
      check_eq("start_seen", tx_log.size() - s, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((m_active || m_full[0] || m_full[1] || tx_busy) && n < 300) begin step(); n++; end
      step();
      check_eq("drain_idle", {grant, req1_ready, req0_ready}, 4'b0011);
   endtask

   initial begin
      int base_log, base_acc;
      model_reset();
      do_reset(3);

      // Single byte with a fixed 10-cycle busy
      emu_fixed = 1; fix_delay = 1; fix_len = 10;
      tx_log.delete();
      offer(1, 0, 8'h41, 8'h00);
      drain();
      check_eq("single_len", tx_log.size(), 1);
      if (tx_log.size() > 0) check_eq("single_byte", tx_log[0], 8'h41);

      // Simultaneous requests alternate starting with port 0
      do_reset(2);
      tx_log.delete();
      fix_len = 3;
      repeat (3) begin
         offer(1, 1, 8'h11, 8'h22);
         drain();
      end
      check_eq("rr_len", tx_log.size(), 6);
      for (int i = 0; i < 6 && i < tx_log.size(); i++)
         check_eq("rr_order", tx_log[i], (i % 2 == 0) ? 8'h11 : 8'h22);

      // Refill port 1 while its first byte is in flight
      tx_log.delete();
      fix_len = 8;
      offer(0, 1, 8'h00, 8'h55);
      wait_start();
      offer(0, 1, 8'h00, 8'h66);
      drain();
      check_eq("refill_len", tx_log.size(), 2);
      if (tx_log.size() == 2) begin
         check_eq("refill_first", tx_log[0], 8'h55);
         check_eq("refill_second", tx_log[1], 8'h66);
      end

      // Busy never rises: timeout flag is sticky, next byte still goes out
      tx_log.delete();
      emu_ignore = 1;
      offer(1, 0, 8'h77, 8'h00);
      repeat (12) step();
      check_eq("timeout_set", err_timeout, 1'b1);
      emu_ignore = 0;
      offer(1, 0, 8'h78, 8'h00);
      drain();
      check_eq("timeout_sticky", err_timeout, 1'b1);
      check_eq("timeout_len", tx_log.size(), 2);
      if (tx_log.size() == 2) check_eq("after_timeout", tx_log[1], 8'h78);

      // Reset during WAIT_DONE with both buffers full
      fix_len = 12;
      offer(1, 0, 8'h90, 8'h00);
      wait_start();
      repeat (3) step();
      offer(1, 1, 8'hA0, 8'hB0);
      check_eq("both_full", {req1_ready, req0_ready}, 2'b00);
      do_reset(2);
      base_log = tx_log.size();
      repeat (20) step();
      check_eq("no_start_after_rst", tx_log.size(), base_log);

      // Random producers and random busy behaviour
      emu_fixed = 0;
      base_log = tx_log.size();
      base_acc = acc_total;
      for (int c = 0; c < 500; c++) begin
         if (!req0_valid && $urandom_range(0, 2) == 0) begin
            req0_valid = 1'b1; req0_data = 8'($urandom);
         end
         if (!req1_valid && $urandom_range(0, 2) == 0) begin
            req1_valid = 1'b1; req1_data = 8'($urandom);
         end
         step();
         if (m_acc[0]) req0_valid = 1'b0;
         if (m_acc[1]) req1_valid = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain();
      check_eq("rnd_count", tx_log.size() - base_log, acc_total - base_acc);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
